// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one req/gnt/rvalid memory port
//                between the core path (C) and the loader/debug path (L).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [DW/8-1:0] c_be,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    output logic            c_gnt,
    output logic            c_rvalid,
    output logic [DW-1:0]   c_rdata,
    output logic            c_err,
    input  logic            l_req,
    input  logic            l_we,
    input  logic [DW/8-1:0] l_be,
    input  logic [AW-1:0]   l_addr,
    input  logic [DW-1:0]   l_wdata,
    output logic            l_gnt,
    output logic            l_rvalid,
    output logic [DW-1:0]   l_rdata,
    output logic            l_err,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = C, 1 = L
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [DW/8-1:0]   be_q, be_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              c_rvalid_q, c_rvalid_d, l_rvalid_q, l_rvalid_d;
    logic              c_err_q, c_err_d, l_err_q, l_err_d;
    logic [DW-1:0]     c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
    logic              rsp_en, rsp_err;
    logic [DW-1:0]     rsp_data;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        c_gnt    = 1'b0;
        l_gnt    = 1'b0;
        rsp_en   = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;

        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes first
                if (c_req && (!l_req || last_q)) begin
                    c_gnt = 1'b1;
                end else if (l_req) begin
                    l_gnt = 1'b1;
                end
                if (c_gnt || l_gnt) begin
                    we_d    = l_gnt ? l_we    : c_we;
                    be_d    = l_gnt ? l_be    : c_be;
                    addr_d  = l_gnt ? l_addr  : c_addr;
                    wdata_d = l_gnt ? l_wdata : c_wdata;
                    owner_d = l_gnt;
                    last_d  = l_gnt;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_gnt) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_en  = 1'b1;
                    rsp_err = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (m_rvalid) begin
                    rsp_en   = 1'b1;
                    rsp_data = we_q ? '0 : m_rdata;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        c_rvalid_d = rsp_en && !owner_q;
        l_rvalid_d = rsp_en &&  owner_q;
        c_err_d    = c_rvalid_d && rsp_err;
        l_err_d    = l_rvalid_d && rsp_err;
        c_rdata_d  = c_rvalid_d ? rsp_data : c_rdata_q;
        l_rdata_d  = l_rvalid_d ? rsp_data : l_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            c_err_q    <= c_err_d;
            l_err_q    <= l_err_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

    assign m_req    = (state_q == S_ISSUE);
    assign m_we     = we_q;
    assign m_be     = be_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_err    = c_err_q;
    assign l_err    = l_err_q;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;
    assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            c_req, c_we, l_req, l_we;
    logic [DW/8-1:0] c_be, l_be;
    logic [AW-1:0]   c_addr, l_addr;
    logic [DW-1:0]   c_wdata, l_wdata;
    logic            c_gnt, c_rvalid, c_err, l_gnt, l_rvalid, l_err;
    logic [DW-1:0]   c_rdata, l_rdata;
    logic            m_req, m_we, m_gnt, m_rvalid;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait transaction starting in a settled IDLE cycle with the request up.
    task automatic do_txn(input logic exp_l, input logic [DW-1:0] rd, input logic is_wr);
        check("gnt_c", c_gnt, !exp_l);
        check("gnt_l", l_gnt, exp_l);
        tick();
        check("issue_state", state, 2'd1);
        check("issue_mreq", m_req, 1'b1);
        check("issue_nognt", {c_gnt, l_gnt}, 2'b00);
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        check("wait_state", state, 2'd2);
        check("wait_mreq", m_req, 1'b0);
        m_rvalid = 1'b1;
        m_rdata  = rd;
        tick();
        m_rvalid = 1'b0;
        #1;
        check("rsp_rvalid", exp_l ? l_rvalid : c_rvalid, 1'b1);
        check("rsp_other",  exp_l ? c_rvalid : l_rvalid, 1'b0);
        check("rsp_err",    exp_l ? l_err    : c_err,    1'b0);
        check("rsp_rdata",  exp_l ? l_rdata  : c_rdata,  is_wr ? '0 : rd);
        check("rsp_idle",   state, 2'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_be = '0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_be = '0; l_addr = '0; l_wdata = '0;
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_state", state, 2'd0);
        check("rst_mreq", m_req, 1'b0);
        check("rst_rvalid", {c_rvalid, l_rvalid, c_err, l_err}, 4'b0);
        check("rst_rdata", {c_rdata, l_rdata}, 64'd0);
        tick();

        // Core read 0x10
        c_req = 1; c_we = 0; c_be = 4'hF; c_addr = 32'h10;
        #1;
        do_txn(1'b0, 32'h0012_3456, 1'b0);
        c_req = 0;
        tick();
        check("c_rvalid_pulse", c_rvalid, 1'b0);

        // Loader write with three ISSUE cycles before acceptance
        l_req = 1; l_we = 1; l_be = 4'hF; l_addr = 32'h40; l_wdata = 32'hCAFE_BABE;
        #1;
        check("lw_gnt", l_gnt, 1'b1);
        check("lw_cgnt", c_gnt, 1'b0);
        tick();
        l_req = 0;
        for (int i = 0; i < 4; i++) begin
            check("lw_mreq", m_req, 1'b1);
            check("lw_fields", {m_we, m_be, m_addr, m_wdata}, {1'b1, 4'hF, 32'h40, 32'hCAFE_BABE});
            if (i == 3) m_gnt = 1'b1;
            tick();
        end
        m_gnt = 0;
        check("lw_wait", state, 2'd2);
        m_rvalid = 1; m_rdata = 32'h1111_2222;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            m_rvalid = 0;
            if (l_rvalid) begin
                cnt++;
                check("lw_err", l_err, 1'b0);
                check("lw_rdata", l_rdata, 32'h0);
            end
            check("lw_c_quiet", c_rvalid, 1'b0);
        end
        check("lw_pulses", cnt, 1);
        check("c_rdata_hold", c_rdata, 32'h0012_3456);

        // Ties out of reset alternate C, L, C, L
        rst = 1; tick(); rst = 0;
        c_req = 1; c_we = 0; c_addr = 32'h100;
        l_req = 1; l_we = 0; l_addr = 32'h200;
        #1;
        do_txn(1'b0, 32'hA1, 1'b0);
        do_txn(1'b1, 32'hB2, 1'b0);
        do_txn(1'b0, 32'hC3, 1'b0);
        check("rr4_gnt_c", c_gnt, 1'b0);
        check("rr4_gnt_l", l_gnt, 1'b1);
        tick();
        c_req = 0; l_req = 0;
        m_gnt = 1; tick(); m_gnt = 0;
        m_rvalid = 1; m_rdata = 32'hD4; tick(); m_rvalid = 0;
        check("rr4_l_rsp", {l_rvalid, l_rdata}, {1'b1, 32'hD4});
        tick();

        // Timeout with m_gnt held low
        c_req = 1; c_we = 0; c_addr = 32'h80;
        #1;
        check("to_gnt", c_gnt, 1'b1);
        tick();
        c_req = 0;
        cnt = 0;
        for (int i = 0; i < 40 && !c_rvalid; i++) begin
            if (m_req) cnt++;
            tick();
        end
        check("to_mreq_cycles", cnt, TIMEOUT);
        check("to_rsp", {c_rvalid, c_err, c_rdata, m_req}, {1'b1, 1'b1, 32'h0, 1'b0});
        check("to_state", state, 2'd0);
        c_req = 1;
        #1;
        do_txn(1'b0, 32'h55, 1'b0);
        c_req = 0;
        tick();

        // Reset while waiting on a loader read
        l_req = 1; l_we = 0; l_addr = 32'h300;
        #1;
        check("rw_gnt", l_gnt, 1'b1);
        tick();
        l_req = 0; m_gnt = 1;
        tick();
        m_gnt = 0;
        check("rw_wait", state, 2'd2);
        rst = 1;
        tick();
        rst = 0;
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        #1;
        check("rw_state", state, 2'd0);
        check("rw_mreq", m_req, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            m_rvalid = 0;
            if (l_rvalid || c_rvalid) cnt++;
        end
        check("rw_no_rsp", cnt, 0);
        check("rw_lrdata", l_rdata, 32'h0);
        c_req = 1; c_addr = 32'h500;
        #1;
        do_txn(1'b0, 32'h7777, 1'b0);
        c_req = 0;
        tick();

        // Back-to-back core reads
        c_req = 1; c_addr = 32'h600;
        #1;
        do_txn(1'b0, 32'h61, 1'b0);
        check("b2b_same_cycle", {c_rvalid, c_gnt}, 2'b11);
        do_txn(1'b0, 32'h62, 1'b0);
        c_req = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
